// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: cycle phases,
// FSM state encoding and the opcode nibbles that start two-word instructions.
package fetch_unit_pkg;

    localparam logic [2:0] CYC_A1 = 3'd0;
    localparam logic [2:0] CYC_A2 = 3'd1;
    localparam logic [2:0] CYC_A3 = 3'd2;
    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X1 = 3'd5;
    localparam logic [2:0] CYC_X2 = 3'd6;
    localparam logic [2:0] CYC_X3 = 3'd7;

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } fetch_state_e;

    localparam logic [3:0] OPR_JCN = 4'h1;
    localparam logic [3:0] OPR_FIM = 4'h2;
    localparam logic [3:0] OPR_JUN = 4'h4;
    localparam logic [3:0] OPR_JMS = 4'h5;
    localparam logic [3:0] OPR_ISZ = 4'h7;

endpackage

// File: rtl/fetch_unit_decode.sv
// Combinational classifier: does this opcode byte need a second ROM word?
// FIM shares its high nibble with SRC; only the even low nibble is two-word.
module two_word_decode
    import fetch_unit_pkg::*;
(
    input  logic [3:0] opr,
    input  logic [3:0] opa,
    output logic       is_two_word
);

    always_comb begin
        is_two_word = 1'b0;
        unique case (opr)
            OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: is_two_word = 1'b1;
            OPR_FIM: is_two_word = ~opa[0];
            default: is_two_word = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives the PC onto the bus in A1-A3, captures opcode
// or second word in M1/M2, and advances or jumps the PC at X3.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        toggle_clk,
    input  logic        rst_n,
    input  logic [2:0]  cycle,
    input  logic        sync,
    input  logic [3:0]  rom_data,
    input  logic        jump_en,
    input  logic [11:0] jump_addr,
    output logic [3:0]  bus_out,
    output logic        bus_oe,
    output logic [11:0] pc,
    output logic [3:0]  opr,
    output logic [3:0]  opa,
    output logic [7:0]  word2,
    output logic        two_word,
    output logic        instr_valid
);

    fetch_state_e state;
    logic         dec_two;

    two_word_decode u_decode (
        .opr         (opr),
        .opa         (rom_data),
        .is_two_word (dec_two)
    );

    always_comb begin
        bus_out = 4'h0;
        unique case (cycle)
            CYC_A1:  bus_out = pc[3:0];
            CYC_A2:  bus_out = pc[7:4];
            CYC_A3:  bus_out = pc[11:8];
            default: bus_out = 4'h0;
        endcase
    end

    assign bus_oe = (cycle == CYC_A1) || (cycle == CYC_A2) ||
                    (cycle == CYC_A3);

    // instr_valid is a one-clock pulse; every edge not completing M2 clears it
    always_ff @(posedge toggle_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FIRST;
            pc          <= 12'h000;
            opr         <= 4'h0;
            opa         <= 4'h0;
            word2       <= 8'h00;
            two_word    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            if (sync) begin
                pc <= jump_en ? jump_addr : pc + 12'd1;
                if (jump_en)
                    state <= ST_FIRST;
                else if (state == ST_FIRST && two_word)
                    state <= ST_SECOND;
                else
                    state <= ST_FIRST;
            end else if (cycle == CYC_M1) begin
                if (state == ST_FIRST)
                    opr <= rom_data;
                else
                    word2[7:4] <= rom_data;
            end else if (cycle == CYC_M2) begin
                if (state == ST_FIRST) begin
                    opa         <= rom_data;
                    two_word    <= dec_two;
                    instr_valid <= ~dec_two;
                end else begin
                    word2[3:0]  <= rom_data;
                    instr_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed instruction table, reset-abort sequence,
// and random instruction streams against an instruction-level model.
module tb_fetch_unit;

    logic        toggle_clk = 1'b0;
    logic        rst_n;
    logic [2:0]  cycle;
    logic        sync;
    logic [3:0]  rom_data;
    logic        jump_en;
    logic [11:0] jump_addr;
    logic [3:0]  bus_out;
    logic        bus_oe;
    logic [11:0] pc;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic [7:0]  word2;
    logic        two_word;
    logic        instr_valid;

    fetch_unit dut (
        .toggle_clk  (toggle_clk),
        .rst_n       (rst_n),
        .cycle       (cycle),
        .sync        (sync),
        .rom_data    (rom_data),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .bus_out     (bus_out),
        .bus_oe      (bus_oe),
        .pc          (pc),
        .opr         (opr),
        .opa         (opa),
        .word2       (word2),
        .two_word    (two_word),
        .instr_valid (instr_valid)
    );

    always #5 toggle_clk = ~toggle_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // instruction-level reference state
    int m_pc, m_opr, m_opa, m_w2, m_two, m_pending, m_valid;

    typedef struct {
        logic [3:0]  n1;
        logic [3:0]  n2;
        logic        jen;
        logic [11:0] ja;
        logic [3:0]  opr;
        logic [3:0]  opa;
        logic        two;
        logic        vld;
        logic [7:0]  w2;
        logic [11:0] pc;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int needs_second(input int n1, input int n2);
        return (n1 == 1 || n1 == 4 || n1 == 5 || n1 == 7 ||
                (n1 == 2 && n2 % 2 == 0)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_opr = 0; m_opa = 0; m_w2 = 0;
        m_two = 0; m_pending = 0; m_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle = 3'd0; sync = 1'b0; rom_data = 4'h0;
        jump_en = 1'b0; jump_addr = 12'h000;
        repeat (2) @(posedge toggle_clk);
        #1;
        check("rst_pc", pc, 0);
        check("rst_regs", {opr, opa, word2, two_word, instr_valid}, 0);
        check("rst_bus", {bus_oe, bus_out}, 5'h10);
        rst_n = 1'b1;
        model_reset();
    endtask

    // one full A1..X3 instruction cycle with checks against the model
    task automatic do_instr(input int n1, input int n2,
                            input int jen, input int ja);
        logic [7:0] vmask;
        int was_second;
        vmask = 8'h00;
        for (int p = 0; p < 8; p++) begin
            cycle     = 3'(p);
            sync      = (p == 7);
            rom_data  = (p == 3) ? 4'(n1) : (p == 4) ? 4'(n2) : 4'h0;
            jump_en   = (p == 7) ? 1'(jen) : 1'b0;
            jump_addr = 12'(ja);
            #1;
            if (p < 3)
                check("bus_a", {bus_oe, bus_out}, 16 + ((m_pc >> (4 * p)) % 16));
            else if (p == 5)
                check("bus_idle", {bus_oe, bus_out}, 0);
            @(posedge toggle_clk);
            #1;
            vmask[p] = instr_valid;
        end
        was_second = m_pending;
        if (was_second != 0) begin
            m_w2    = n1 * 16 + n2;
            m_valid = 1;
        end else begin
            m_opr   = n1;
            m_opa   = n2;
            m_two   = needs_second(n1, n2);
            m_valid = 1 - m_two;
        end
        m_pending = (was_second == 0 && m_two != 0 && jen == 0) ? 1 : 0;
        m_pc      = (jen != 0) ? ja : (m_pc + 1) % 4096;
        check("pc", pc, m_pc);
        check("opr_opa", {opr, opa}, m_opr * 16 + m_opa);
        check("word2", word2, m_w2);
        check("two_word", two_word, m_two);
        check("valid_pulse", vmask, (m_valid != 0) ? 8'h10 : 8'h00);
    endtask

    initial begin
        tbl[0]  = '{4'hD, 4'h5, 1'b0, 12'h000, 4'hD, 4'h5, 1'b0, 1'b1, 8'h00, 12'h001};
        tbl[1]  = '{4'h4, 4'h4, 1'b0, 12'h000, 4'h4, 4'h4, 1'b1, 1'b0, 8'h00, 12'h002};
        tbl[2]  = '{4'hA, 4'h5, 1'b1, 12'h4A5, 4'h4, 4'h4, 1'b1, 1'b1, 8'hA5, 12'h4A5};
        tbl[3]  = '{4'h2, 4'h1, 1'b0, 12'h000, 4'h2, 4'h1, 1'b0, 1'b1, 8'hA5, 12'h4A6};
        tbl[4]  = '{4'h2, 4'h0, 1'b0, 12'h000, 4'h2, 4'h0, 1'b1, 1'b0, 8'hA5, 12'h4A7};
        tbl[5]  = '{4'h3, 4'hC, 1'b0, 12'h000, 4'h2, 4'h0, 1'b1, 1'b1, 8'h3C, 12'h4A8};
        tbl[6]  = '{4'h4, 4'h0, 1'b1, 12'hFFF, 4'h4, 4'h0, 1'b1, 1'b0, 8'h3C, 12'hFFF};
        tbl[7]  = '{4'hD, 4'h1, 1'b0, 12'h000, 4'hD, 4'h1, 1'b0, 1'b1, 8'h3C, 12'h000};
        tbl[8]  = '{4'h1, 4'h2, 1'b1, 12'h123, 4'h1, 4'h2, 1'b1, 1'b0, 8'h3C, 12'h123};
        tbl[9]  = '{4'hF, 4'h0, 1'b0, 12'h000, 4'hF, 4'h0, 1'b0, 1'b1, 8'h3C, 12'h124};
        tbl[10] = '{4'h7, 4'h3, 1'b0, 12'h000, 4'h7, 4'h3, 1'b1, 1'b0, 8'h3C, 12'h125};
        tbl[11] = '{4'h5, 4'h5, 1'b0, 12'h000, 4'h7, 4'h3, 1'b1, 1'b1, 8'h55, 12'h126};
        tbl[12] = '{4'h5, 4'h5, 1'b0, 12'h000, 4'h5, 4'h5, 1'b1, 1'b0, 8'h55, 12'h127};
        tbl[13] = '{4'h0, 4'h0, 1'b1, 12'h800, 4'h5, 4'h5, 1'b1, 1'b1, 8'h00, 12'h800};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            do_instr(tbl[i].n1, tbl[i].n2, tbl[i].jen, tbl[i].ja);
            check($sformatf("tbl%0d_regs", i),
                  {pc, opr, opa, word2, two_word},
                  {tbl[i].pc, tbl[i].opr, tbl[i].opa, tbl[i].w2, tbl[i].two});
            check($sformatf("tbl%0d_valid", i),
                  (m_valid != 0), tbl[i].vld);
        end

        // reset asserted at M1 of a pending second word
        do_reset();
        do_instr(2, 0, 0, 0);
        for (int p = 0; p < 3; p++) begin
            cycle = 3'(p); sync = 1'b0; rom_data = 4'h0;
            @(posedge toggle_clk);
            #1;
        end
        cycle = 3'd3; rom_data = 4'h9;
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_regs", {pc, opr, opa, word2, two_word, instr_valid}, 0);
        check("abort_bus_m1", {bus_oe, bus_out}, 0);
        @(posedge toggle_clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        do_instr(13, 5, 0, 0);

        // random instruction streams
        do_reset();
        for (int i = 0; i < 300; i++) begin
            do_instr(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     ($urandom_range(0, 3) == 0) ? 1 : 0,
                     int'($urandom_range(0, 4095)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
